// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit: opcodes and FSM states.
package md_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_e;

endpackage

// File: rtl/md_div_core.sv
// Unsigned restoring divider: one quotient bit per cycle, WIDTH cycles per divide.
// valid pulses for one cycle once quotient/remainder hold the final result.
module md_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cancel,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             valid
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dsor_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;
  logic             valid_q;
  logic [WIDTH:0]   trial;

  // Partial remainder with the next dividend bit shifted in, minus the divisor;
  // the top bit set means the subtraction went negative and must be discarded.
  assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dsor_q};

  // Iteration register: load on start, then shift/subtract until the count expires.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      quo_q   <= '0;
      rem_q   <= '0;
      dsor_q  <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (cancel) begin
        run_q <= 1'b0;
      end else if (start) begin
        quo_q  <= dividend;
        rem_q  <= '0;
        dsor_q <= divisor;
        cnt_q  <= CNT_W'(WIDTH - 1);
        run_q  <= 1'b1;
      end else if (run_q) begin
        if (!trial[WIDTH]) begin
          rem_q <= trial[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_q <= {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
          quo_q <= {quo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          run_q   <= 1'b0;
          valid_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign valid     = valid_q;

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers for the EX stage.
// Multiply result is computed at issue and held for MUL_CYCLES busy cycles;
// divide runs the iterative core on magnitudes, then one sign-fix cycle.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             cancel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CNT_MAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  state_e             state_q, state_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [WIDTH-1:0]   hi_n, lo_n;
  logic               done_n;
  logic               load_mul, load_div;

  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   a_q;
  logic               neg_quo_q, neg_rem_q, dz_q;

  logic signed [2*WIDTH-1:0] a_sx, b_sx, mul_s;
  logic        [2*WIDTH-1:0] a_zx, b_zx, mul_u;
  logic                      a_neg, b_neg;
  logic        [WIDTH-1:0]   a_mag, b_mag;
  logic        [WIDTH-1:0]   div_quo, div_rem;
  logic                      div_valid;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (-v) : v;
  endfunction

  assign a_sx  = {{WIDTH{A[WIDTH-1]}}, A};
  assign b_sx  = {{WIDTH{B[WIDTH-1]}}, B};
  assign a_zx  = {{WIDTH{1'b0}}, A};
  assign b_zx  = {{WIDTH{1'b0}}, B};
  assign mul_s = a_sx * b_sx;
  assign mul_u = a_zx * b_zx;

  assign a_neg = (op == OP_DIV) && A[WIDTH-1];
  assign b_neg = (op == OP_DIV) && B[WIDTH-1];
  assign a_mag = cond_neg(A, a_neg);
  assign b_mag = cond_neg(B, b_neg);

  md_div_core #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (load_div),
    .cancel    (cancel),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (div_quo),
    .remainder (div_rem),
    .valid     (div_valid)
  );

  // Next-state, counter and HI/LO update decisions.
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    hi_n     = HI;
    lo_n     = LO;
    done_n   = 1'b0;
    load_mul = 1'b0;
    load_div = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !cancel) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              load_mul = 1'b1;
              state_n  = S_MUL;
              cnt_n    = CNT_W'(MUL_CYCLES - 1);
            end
            OP_DIV, OP_DIVU: begin
              load_div = 1'b1;
              state_n  = S_DIV;
              cnt_n    = CNT_W'(WIDTH - 1);
            end
            OP_MTHI: hi_n = A;
            OP_MTLO: lo_n = A;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (cancel) begin
          state_n = S_IDLE;
        end else if (cnt_q == '0) begin
          {hi_n, lo_n} = prod_q;
          done_n       = 1'b1;
          state_n      = S_IDLE;
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end
      S_DIV: begin
        if (cancel) begin
          state_n = S_IDLE;
        end else if (cnt_q == '0) begin
          state_n = S_FIX;
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end
      S_FIX: begin
        state_n = S_IDLE;
        if (!cancel && div_valid) begin
          done_n = 1'b1;
          if (dz_q) begin
            hi_n = a_q;
            lo_n = '1;
          end else begin
            hi_n = cond_neg(div_rem, neg_rem_q);
            lo_n = cond_neg(div_quo, neg_quo_q);
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, counter, outputs and the operands/flags captured at issue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      HI        <= '0;
      LO        <= '0;
      done      <= 1'b0;
      prod_q    <= '0;
      a_q       <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      HI      <= hi_n;
      LO      <= lo_n;
      done    <= done_n;
      if (load_mul) begin
        prod_q <= (op == OP_MULT) ? mul_s : mul_u;
      end
      if (load_div) begin
        a_q       <= A;
        neg_quo_q <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
        dz_q      <= (B == '0);
      end
    end
  end

  assign Busy = (state_q != S_IDLE);

endmodule
